// File: rtl/audio_stream_sequencer.sv
// -----------------------------------------------------------------------------
// audio_stream_sequencer
//
// Moves one stereo sample at a time from the codec input FIFO through an
// external effect datapath and into the codec output FIFO. It supports bypass,
// which forwards the raw sample, and mute, which forces zero output. An
// optional watchdog falls back to the raw sample when the datapath stalls.
//
// Optional feature macro: PROC_WATCHDOG_EN
//   defined   : the PROC state times out after TIMEOUT_CYC cycles and sets
//               timeout_flag. The flag is sticky and is cleared by clr_timeout.
//   undefined : PROC waits for proc_done indefinitely. timeout_flag is tied
//               to 0 and clr_timeout is ignored.
//
// Parameters:
//   DATA_W       sample width per channel (signed two's complement)
//   TIMEOUT_CYC  PROC cycles allowed before fallback (watchdog builds only)
//
// Ports:
//   CLOCK_50            system clock
//   reset               asynchronous, active-high reset
//   audio_in_available  codec input FIFO is non-empty
//   audio_out_allowed   codec output FIFO has space
//   audio_in_L/R        codec input samples
//   read_audio_in       one-cycle pop pulse to the codec input FIFO
//   write_audio_out     one-cycle push pulse to the codec output FIFO
//   audio_out_L/R       registered output samples, held between writes
//   proc_start          one-cycle start pulse to the effect datapath
//   proc_in_L/R         captured sample, held until the next capture
//   proc_done           datapath result valid (single cycle)
//   proc_out_L/R        datapath result, valid while proc_done is high
//   bypass              forward the raw sample (sampled at capture only)
//   mute                force zero output (sampled in the write cycle)
//   clr_timeout         clears timeout_flag
//   busy                high whenever the FSM is not in IDLE
//   timeout_flag        sticky watchdog expiry indicator
// -----------------------------------------------------------------------------
module audio_stream_sequencer #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              audio_in_available,
    input  logic              audio_out_allowed,
    input  logic [DATA_W-1:0] audio_in_L,
    input  logic [DATA_W-1:0] audio_in_R,
    output logic              read_audio_in,
    output logic              write_audio_out,
    output logic [DATA_W-1:0] audio_out_L,
    output logic [DATA_W-1:0] audio_out_R,
    output logic              proc_start,
    output logic [DATA_W-1:0] proc_in_L,
    output logic [DATA_W-1:0] proc_in_R,
    input  logic              proc_done,
    input  logic [DATA_W-1:0] proc_out_L,
    input  logic [DATA_W-1:0] proc_out_R,
    input  logic              bypass,
    input  logic              mute,
    input  logic              clr_timeout,
    output logic              busy,
    output logic              timeout_flag
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROC,
        S_OUT_WAIT
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              w_capture;
    logic              w_take_done;
    logic              w_expire;
    logic              w_emit;
    logic              w_wd_hit;

    logic              r_read;
    logic              r_write;
    logic              r_start;
    logic              r_busy;
    logic [DATA_W-1:0] r_in_L;
    logic [DATA_W-1:0] r_in_R;
    logic [DATA_W-1:0] r_res_L;
    logic [DATA_W-1:0] r_res_R;
    logic [DATA_W-1:0] r_out_L;
    logic [DATA_W-1:0] r_out_R;

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
`ifdef PROC_WATCHDOG_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_timeout;

    assign w_wd_hit = (r_state == S_PROC) &&
                      (r_wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // The count restarts on every capture, so it reads 0 in the first PROC
    // cycle. It stops advancing at the terminal value.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= '0;
        end else if (w_capture) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_PROC && !w_wd_hit) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // When expiry and clear happen in the same cycle, expiry takes priority.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else if (w_expire) begin
            r_timeout <= 1'b1;
        end else if (clr_timeout) begin
            r_timeout <= 1'b0;
        end
    end

    assign timeout_flag = r_timeout;
`else
    logic w_unused_wd;

    assign w_wd_hit     = 1'b0;
    assign w_unused_wd  = clr_timeout ^ (TIMEOUT_CYC > 0);
    assign timeout_flag = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_take_done = 1'b0;
        w_expire    = 1'b0;
        w_emit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (audio_in_available) begin
                    w_capture = 1'b1;
                    w_next    = bypass ? S_OUT_WAIT : S_PROC;
                end
            end
            S_PROC: begin
                // A result that arrives in the expiry cycle is still used.
                if (proc_done) begin
                    w_take_done = 1'b1;
                    w_next      = S_OUT_WAIT;
                end else if (w_wd_hit) begin
                    w_expire = 1'b1;
                    w_next   = S_OUT_WAIT;
                end
            end
            S_OUT_WAIT: begin
                if (audio_out_allowed) begin
                    w_emit = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs and sample path
    // -------------------------------------------------------------------------
    // The result register is loaded with the raw sample at capture. Bypass
    // and watchdog fallback therefore need no extra load. Only a datapath
    // result overwrites it.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_in_L  <= '0;
            r_in_R  <= '0;
            r_res_L <= '0;
            r_res_R <= '0;
            r_out_L <= '0;
            r_out_R <= '0;
        end else begin
            r_read  <= w_capture;
            r_start <= w_capture & ~bypass;
            r_write <= w_emit;
            r_busy  <= (w_next != S_IDLE);
            if (w_capture) begin
                r_in_L  <= audio_in_L;
                r_in_R  <= audio_in_R;
                r_res_L <= audio_in_L;
                r_res_R <= audio_in_R;
            end
            if (w_take_done) begin
                r_res_L <= proc_out_L;
                r_res_R <= proc_out_R;
            end
            if (w_emit) begin
                r_out_L <= mute ? '0 : r_res_L;
                r_out_R <= mute ? '0 : r_res_R;
            end
        end
    end

    assign read_audio_in   = r_read;
    assign write_audio_out = r_write;
    assign proc_start      = r_start;
    assign busy            = r_busy;
    assign proc_in_L       = r_in_L;
    assign proc_in_R       = r_in_R;
    assign audio_out_L     = r_out_L;
    assign audio_out_R     = r_out_R;

endmodule

// File: doc/audio_stream_sequencer.md
Name: audio_stream_sequencer

Overview:
- Sequences one stereo sample at a time through the codec handshake: pop from the codec input FIFO, hand the sample to an external effect datapath with a start/done handshake, then push the result to the codec output FIFO.
- Sits between the codec controller signals on top and the effect processing chain.
- Provides bypass, mute and a processing-timeout watchdog.

Parameters:
DATA_W, 32, sample width per channel, signed two's complement
TIMEOUT_CYC, 1024, cycles to wait for proc_done before falling back to the raw sample (only with watchdog compiled in)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
audio_in_available  in  1  codec input FIFO non-empty
audio_out_allowed  in  1  codec output FIFO has space
audio_in_L  in  DATA_W  codec left input sample, signed
audio_in_R  in  DATA_W  codec right input sample, signed
read_audio_in  out  1  one-cycle pop pulse to codec input FIFO
write_audio_out  out  1  one-cycle push pulse to codec output FIFO
audio_out_L  out  DATA_W  left output sample, registered
audio_out_R  out  DATA_W  right output sample, registered
proc_start  out  1  one-cycle start pulse to effect datapath
proc_in_L  out  DATA_W  captured left sample to datapath, held until next capture
proc_in_R  out  DATA_W  captured right sample to datapath
proc_done  in  1  datapath result valid, single cycle
proc_out_L  in  DATA_W  datapath left result, valid with proc_done
proc_out_R  in  DATA_W  datapath right result
bypass  in  1  skip datapath, forward raw sample
mute  in  1  force output samples to 0
clr_timeout  in  1  clears timeout_flag
busy  out  1  high whenever state is not IDLE
timeout_flag  out  1  sticky; set on watchdog expiry

Behaviour:
- Reset: async. State IDLE. All outputs are 0: pulses, samples, proc_in_*, busy and timeout_flag. Any in-flight sample is discarded and no write is issued.
- Outputs are registered. Pulses are exactly one cycle wide.
- FSM states: IDLE, PROC, OUT_WAIT.
- IDLE:
  - When audio_in_available=1, latch audio_in_L/R into proc_in_L/R.
  - Assert read_audio_in on the next cycle.
  - Next state is OUT_WAIT if bypass=1, with result = raw sample. Otherwise next state is PROC, with proc_start asserted on the next cycle.
  - bypass is sampled only at the capture edge.
- PROC:
  - Wait for proc_done. On proc_done=1, latch proc_out_L/R as the result and go to OUT_WAIT.
  - proc_done is ignored in every other state.
- OUT_WAIT:
  - When audio_out_allowed=1, drive audio_out_L/R = result, or 0 if mute=1 in that cycle.
  - Assert write_audio_out on the next cycle, then return to IDLE.
  - audio_out_L/R hold their value between writes.
- Latency with bypass=1 and both flags high from cycle 0:
  - read_audio_in is high in cycle 1.
  - write_audio_out and the new audio_out values appear in cycle 2.
- Latency with bypass=0:
  - proc_start is high in cycle 1.
  - If proc_done arrives in cycle k, write_audio_out is high in cycle k+2 when audio_out_allowed is already high.
- New samples are not captured while busy. The codec FIFO provides backpressure, so there is no internal loss.
- clr_timeout clears timeout_flag. If expiry and clr_timeout occur in the same cycle, set wins.

Optional Feature:
PROC_WATCHDOG_EN
- Defined:
  - A counter starts at 0 on entry to PROC and increments each cycle.
  - If it reaches TIMEOUT_CYC-1 without proc_done, result = captured raw sample, timeout_flag is set, and the state moves to OUT_WAIT.
  - If proc_done arrives in the same cycle as expiry, proc_done wins and the flag is not set.
  - A proc_done arriving late, after the fallback, is ignored.
- Undefined: PROC waits indefinitely. timeout_flag is tied to 0 and clr_timeout is unused.

Test Plan:
- Bypass passthrough: bypass=1, in L=1000 / R=-1000, both flags high -> read pulse in cycle 1; write pulse in cycle 2 with out 1000/-1000.
- Processed path: bypass=0, in 5000/5000; datapath returns 2500/-2500 three cycles after proc_start -> single write with 2500/-2500; proc_start, read and write each pulse exactly once.
- Output backpressure: hold audio_out_allowed=0 for 20 cycles after proc_done -> busy stays high, no write, no second read; raising the flag gives one write.
- Mute: mute=1, in 5000/5000 -> write with 0/0; a later sample with mute=0 outputs normally.
- Watchdog (with PROC_WATCHDOG_EN, TIMEOUT_CYC=8): withhold proc_done, in 700/-700 -> write with 700/-700 and timeout_flag=1; clr_timeout pulse gives 0; done-at-expiry gives the proc result and flag 0.
- Reset mid-PROC: assert reset while in PROC -> all outputs 0 immediately; after release, no write occurs for the discarded sample and the next sample processes normally.
